test_vector_sequencer: RTL and testbench

Synthesizable stimulus sequencer for the FRANK6000 bench. It is the stage directly upstream of the result checker. It steps through a loadable table of test vectors and issues each vector's operands to the device under test with a valid/ready handshake. It then captures the DUT result, or detects a timeout, and presents each actual/expected pair to the checker as a one-cycle report while keeping pass/fail tallies.

---
 rtl/test_vector_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_test_vector_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_vector_sequencer.sv
// test_vector_sequencer
//
// Steps through a loadable table of test vectors, issues each vector's
// operands to the device under test over a valid/ready handshake, captures
// the DUT result (or a timeout) and hands each actual/expected pair to the
// downstream result checker as a one-cycle report, keeping pass/fail tallies.
//
// Optional build macro: SEQ_STOP_ON_FAIL_EN
//   defined   - the first failing report (mismatch or timeout) ends the run.
//   undefined - every vector up to the last index is always run.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_start, i_last_idx     begin a run at index 0; final index of the run
//   i_load_*                table write port (ignored while busy)
//   o_dut_valid/a/b/op      operands to the DUT, i_dut_ready accepts them
//   i_dut_res_valid/res     DUT result, accepted only while waiting for it
//   o_chk_*                 one-cycle report to the checker (fields hold after)
//   o_pass_cnt, o_fail_cnt  tallies for the current/last run
//   o_busy, o_done          run in progress / run finished
module test_vector_sequencer #(
  parameter int  WIDTH   = 8,
  parameter int  DEPTH   = 16,
  parameter int  TIMEOUT = 15,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_last_idx,
  input  logic             i_load_en,
  input  logic [AW-1:0]    i_load_addr,
  input  logic [WIDTH-1:0] i_load_a,
  input  logic [WIDTH-1:0] i_load_b,
  input  logic [WIDTH-1:0] i_load_exp,
  input  logic [2:0]       i_load_op,
  output logic             o_dut_valid,
  output logic [WIDTH-1:0] o_dut_a,
  output logic [WIDTH-1:0] o_dut_b,
  output logic [2:0]       o_dut_op,
  input  logic             i_dut_ready,
  input  logic             i_dut_res_valid,
  input  logic [WIDTH-1:0] i_dut_res,
  output logic             o_chk_valid,
  output logic [AW-1:0]    o_chk_idx,
  output logic [WIDTH-1:0] o_chk_actual,
  output logic [WIDTH-1:0] o_chk_expctd,
  output logic             o_chk_timeout,
  output logic [AW:0]      o_pass_cnt,
  output logic [AW:0]      o_fail_cnt,
  output logic             o_busy,
  output logic             o_done
);

  // Timer must be able to hold TIMEOUT-1; the +1 keeps TW >= 1 for TIMEOUT=1.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Vector table: plain register array, deliberately not reset.
  logic [WIDTH-1:0] tab_a   [DEPTH];
  logic [WIDTH-1:0] tab_b   [DEPTH];
  logic [WIDTH-1:0] tab_exp [DEPTH];
  logic [2:0]       tab_op  [DEPTH];

  logic [AW-1:0]    idx;
  logic [AW-1:0]    last_idx;
  logic [TW-1:0]    timer;
  logic [AW:0]      pass_cnt;
  logic [AW:0]      fail_cnt;
  logic [AW-1:0]    chk_idx;
  logic [WIDTH-1:0] chk_actual;
  logic [WIDTH-1:0] chk_expctd;
  logic             chk_timeout;

  logic busy;
  logic at_last;
  logic tmo_hit;
  logic rpt_pass;

  assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_REPORT);
  assign at_last  = (idx == last_idx);
  assign tmo_hit  = (timer == TW'(TIMEOUT - 1));
  // A timed-out vector always fails, even if the expected value happens to be 0.
  assign rpt_pass = (chk_actual == chk_expctd) && !chk_timeout;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_dut_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_dut_res_valid || tmo_hit) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        state_nxt = at_last ? S_DONE : S_ISSUE;
`ifdef SEQ_STOP_ON_FAIL_EN
        if (!rpt_pass) state_nxt = S_DONE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx         <= '0;
      last_idx    <= '0;
      timer       <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      chk_idx     <= '0;
      chk_actual  <= '0;
      chk_expctd  <= '0;
      chk_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            last_idx <= i_last_idx;
            idx      <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (i_dut_ready) timer <= '0;
        end
        S_WAIT: begin
          if (i_dut_res_valid || tmo_hit) begin
            chk_idx     <= idx;
            chk_expctd  <= tab_exp[idx];
            chk_actual  <= i_dut_res_valid ? i_dut_res : '0;
            chk_timeout <= !i_dut_res_valid;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_REPORT: begin
          if (rpt_pass) pass_cnt <= pass_cnt + (AW+1)'(1);
          else          fail_cnt <= fail_cnt + (AW+1)'(1);
          if (state_nxt == S_ISSUE) idx <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_load_en && !busy) begin
      tab_a[i_load_addr]   <= i_load_a;
      tab_b[i_load_addr]   <= i_load_b;
      tab_exp[i_load_addr] <= i_load_exp;
      tab_op[i_load_addr]  <= i_load_op;
    end
  end

  // Operands are gated by the issue state so the bus reads 0 out of reset
  // even though the table itself is uninitialised.
  assign o_dut_valid   = (state == S_ISSUE);
  assign o_dut_a       = o_dut_valid ? tab_a[idx]  : '0;
  assign o_dut_b       = o_dut_valid ? tab_b[idx]  : '0;
  assign o_dut_op      = o_dut_valid ? tab_op[idx] : '0;

  assign o_chk_valid   = (state == S_REPORT);
  assign o_chk_idx     = chk_idx;
  assign o_chk_actual  = chk_actual;
  assign o_chk_expctd  = chk_expctd;
  assign o_chk_timeout = chk_timeout;

  assign o_pass_cnt    = pass_cnt;
  assign o_fail_cnt    = fail_cnt;
  assign o_busy        = busy;
  assign o_done        = (state == S_DONE);

endmodule

// File: tb/tb_test_vector_sequencer.sv
// tb_test_vector_sequencer
//
// Drives test_vector_sequencer through directed and randomized runs while
// acting as the DUT on the far side of the handshake. Expected reports,
// tallies and timing come from a table-level model of the sequencer rules.
module tb_test_vector_sequencer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;
  localparam int AW      = $clog2(DEPTH);

`ifdef SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [AW-1:0]    i_last_idx = '0;
  logic             i_load_en = 1'b0;
  logic [AW-1:0]    i_load_addr = '0;
  logic [WIDTH-1:0] i_load_a = '0;
  logic [WIDTH-1:0] i_load_b = '0;
  logic [WIDTH-1:0] i_load_exp = '0;
  logic [2:0]       i_load_op = '0;
  logic             o_dut_valid;
  logic [WIDTH-1:0] o_dut_a;
  logic [WIDTH-1:0] o_dut_b;
  logic [2:0]       o_dut_op;
  logic             i_dut_ready = 1'b0;
  logic             i_dut_res_valid = 1'b0;
  logic [WIDTH-1:0] i_dut_res = '0;
  logic             o_chk_valid;
  logic [AW-1:0]    o_chk_idx;
  logic [WIDTH-1:0] o_chk_actual;
  logic [WIDTH-1:0] o_chk_expctd;
  logic             o_chk_timeout;
  logic [AW:0]      o_pass_cnt;
  logic [AW:0]      o_fail_cnt;
  logic             o_busy;
  logic             o_done;

  test_vector_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_last_idx      (i_last_idx),
    .i_load_en       (i_load_en),
    .i_load_addr     (i_load_addr),
    .i_load_a        (i_load_a),
    .i_load_b        (i_load_b),
    .i_load_exp      (i_load_exp),
    .i_load_op       (i_load_op),
    .o_dut_valid     (o_dut_valid),
    .o_dut_a         (o_dut_a),
    .o_dut_b         (o_dut_b),
    .o_dut_op        (o_dut_op),
    .i_dut_ready     (i_dut_ready),
    .i_dut_res_valid (i_dut_res_valid),
    .i_dut_res       (i_dut_res),
    .o_chk_valid     (o_chk_valid),
    .o_chk_idx       (o_chk_idx),
    .o_chk_actual    (o_chk_actual),
    .o_chk_expctd    (o_chk_expctd),
    .o_chk_timeout   (o_chk_timeout),
    .o_pass_cnt      (o_pass_cnt),
    .o_fail_cnt      (o_fail_cnt),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int run_cycles = 0;

  // Model of the table contents as the bench believes them to be.
  logic [WIDTH-1:0] m_a   [DEPTH];
  logic [WIDTH-1:0] m_b   [DEPTH];
  logic [WIDTH-1:0] m_exp [DEPTH];
  logic [2:0]       m_op  [DEPTH];

  // Behaviour of the emulated DUT per vector: cycles of ready held low,
  // WAIT cycle on which the result comes back (-1 = never), result value.
  int               rdy_dly [DEPTH];
  int               rsp_dly [DEPTH];
  logic [WIDTH-1:0] rsp_val [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic load_vec(input int addr, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] e, input logic [2:0] op);
    i_load_en   = 1'b1;
    i_load_addr = AW'(addr);
    i_load_a    = a;
    i_load_b    = b;
    i_load_exp  = e;
    i_load_op   = op;
    m_a[addr]   = a;
    m_b[addr]   = b;
    m_exp[addr] = e;
    m_op[addr]  = op;
    @(negedge i_clk);
    i_load_en = 1'b0;
  endtask

  task automatic set_beh();
    for (int i = 0; i < DEPTH; i++) begin
      rdy_dly[i] = 0;
      rsp_dly[i] = 0;
      rsp_val[i] = m_exp[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dut_valid"}, 32'(o_dut_valid), 0);
    chk({tag, "_dut_a"},     32'(o_dut_a), 0);
    chk({tag, "_chk_valid"}, 32'(o_chk_valid), 0);
    chk({tag, "_chk_idx"},   32'(o_chk_idx), 0);
    chk({tag, "_chk_act"},   32'(o_chk_actual), 0);
    chk({tag, "_chk_to"},    32'(o_chk_timeout), 0);
    chk({tag, "_pass"},      32'(o_pass_cnt), 0);
    chk({tag, "_fail"},      32'(o_fail_cnt), 0);
    chk({tag, "_busy"},      32'(o_busy), 0);
    chk({tag, "_done"},      32'(o_done), 0);
  endtask

  // Entered and left just after a falling edge with all strobes idle.
  // abort_k >= 0 pulls reset during the first WAIT cycle of that vector.
  task automatic run(input int last, input int abort_k, input bit load0);
    int               pass_m = 0;
    int               fail_m = 0;
    int               cyc = 0;
    int               n_wait;
    int               last_k = 0;
    bit               stop = 1'b0;
    bit               exp_to;
    bit               ok;
    logic [WIDTH-1:0] exp_act;

    i_start    = 1'b1;
    i_last_idx = AW'(last);
    if (load0) begin
      i_load_en   = 1'b1;
      i_load_addr = '0;
      i_load_a    = WIDTH'($urandom);
      i_load_b    = WIDTH'($urandom);
      i_load_exp  = i_load_a + i_load_b;
      i_load_op   = 3'($urandom);
      m_a[0]      = i_load_a;
      m_b[0]      = i_load_b;
      m_exp[0]    = i_load_exp;
      m_op[0]     = i_load_op;
      rsp_val[0]  = i_load_exp;
    end
    @(negedge i_clk);
    i_start   = 1'b0;
    i_load_en = 1'b0;

    for (int k = 0; k <= last && !stop; k++) begin
      for (int c = 0; c <= rdy_dly[k]; c++) begin
        chk("issue_valid", 32'(o_dut_valid), 1);
        chk("issue_a",     32'(o_dut_a), 32'(m_a[k]));
        chk("issue_b",     32'(o_dut_b), 32'(m_b[k]));
        chk("issue_op",    32'(o_dut_op), 32'(m_op[k]));
        chk("issue_busy",  32'(o_busy), 1);
        chk("issue_rpt",   32'(o_chk_valid), 0);
        i_dut_ready     = (c == rdy_dly[k]);
        i_dut_res_valid = 1'b1;
        i_dut_res       = 8'hEE;
        @(negedge i_clk);
        cyc++;
      end
      i_dut_ready     = 1'b0;
      i_dut_res_valid = 1'b0;

      n_wait = (rsp_dly[k] < 0) ? TIMEOUT : rsp_dly[k] + 1;
      for (int w = 0; w < n_wait; w++) begin
        if (k == abort_k) begin
          i_rst_n = 1'b0;
          #1;
          check_all_zero("abort");
          @(negedge i_clk);
          i_rst_n = 1'b1;
          return;
        end
        chk("wait_valid", 32'(o_dut_valid), 0);
        chk("wait_rpt",   32'(o_chk_valid), 0);
        if (w == rsp_dly[k]) begin
          i_dut_res_valid = 1'b1;
          i_dut_res       = rsp_val[k];
        end
        @(negedge i_clk);
        cyc++;
        i_dut_res_valid = 1'b0;
      end

      exp_to  = (rsp_dly[k] < 0);
      exp_act = exp_to ? '0 : rsp_val[k];
      ok      = !exp_to && (exp_act == m_exp[k]);
      chk("rpt_valid",  32'(o_chk_valid), 1);
      chk("rpt_idx",    32'(o_chk_idx), 32'(k));
      chk("rpt_actual", 32'(o_chk_actual), 32'(exp_act));
      chk("rpt_expctd", 32'(o_chk_expctd), 32'(m_exp[k]));
      chk("rpt_tmo",    32'(o_chk_timeout), 32'(exp_to));
      chk("rpt_pass0",  32'(o_pass_cnt), 32'(pass_m));
      chk("rpt_fail0",  32'(o_fail_cnt), 32'(fail_m));
      // Start and table writes while busy must have no effect.
      i_start         = 1'b1;
      i_load_en       = 1'b1;
      i_load_addr     = AW'($urandom);
      i_load_a        = WIDTH'($urandom);
      i_load_b        = WIDTH'($urandom);
      i_load_exp      = WIDTH'($urandom);
      i_load_op       = 3'($urandom);
      i_dut_res_valid = 1'b1;
      i_dut_ready     = 1'b1;
      @(negedge i_clk);
      cyc++;
      i_start         = 1'b0;
      i_load_en       = 1'b0;
      i_dut_res_valid = 1'b0;
      i_dut_ready     = 1'b0;
      if (ok) pass_m++;
      else    fail_m++;
      chk("pass_cnt", 32'(o_pass_cnt), 32'(pass_m));
      chk("fail_cnt", 32'(o_fail_cnt), 32'(fail_m));
      last_k = k;
      if (STOP_ON_FAIL && !ok) stop = 1'b1;
    end

    chk("end_done",      32'(o_done), 1);
    chk("end_busy",      32'(o_busy), 0);
    chk("end_dut_valid", 32'(o_dut_valid), 0);
    chk("end_rpt",       32'(o_chk_valid), 0);
    chk("end_idx_hold",  32'(o_chk_idx), 32'(last_k));
    run_cycles = cyc;
  endtask

  initial begin
    int last;

    // Reset state
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_all_zero("post_reset");

    // Directed table: 3+4, 10+5, 9+1, 2+2
    load_vec(0, 8'd3,  8'd4, 8'd7,  3'd1);
    load_vec(1, 8'd10, 8'd5, 8'd15, 3'd2);
    load_vec(2, 8'd9,  8'd1, 8'd10, 3'd3);
    load_vec(3, 8'd2,  8'd2, 8'd4,  3'd4);

    // All correct, 3 cycles per vector; done visible in cycle 13 counting
    // the start cycle as cycle 0.
    set_beh();
    run(3, -1, 1'b0);
    chk("done_cycle", 32'(run_cycles + 1), 13);

    // Mismatch on idx 1
    set_beh();
    rsp_val[1] = 8'h0E;
    run(3, -1, 1'b0);

    // Timeout on idx 2
    set_beh();
    rsp_dly[2] = -1;
    run(3, -1, 1'b0);

    // Ready held low for 5 cycles, with and without a later timeout
    set_beh();
    rdy_dly[0] = 5;
    rsp_dly[0] = -1;
    rdy_dly[1] = 5;
    rsp_dly[1] = 2;
    run(3, -1, 1'b0);

    // Reset in WAIT of idx 2, then a clean rerun from idx 0
    set_beh();
    run(3, 2, 1'b0);
    @(negedge i_clk);
    check_all_zero("after_abort");
    run(3, -1, 1'b0);

    // Single-vector run, with entry 0 rewritten on the start edge
    set_beh();
    run(0, -1, 1'b1);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        load_vec(i, a, b, a + b, 3'($urandom));
      end
      for (int i = 0; i < DEPTH; i++) begin
        rdy_dly[i] = $urandom_range(2, 0);
        rsp_dly[i] = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(3, 0));
        rsp_val[i] = ($urandom_range(2, 0) != 0) ? m_exp[i] : WIDTH'($urandom);
      end
      last = $urandom_range(DEPTH - 1, 0);
      run(last, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
